// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Multi-cycle next-PC sequencer for the RV32 core. It walks IDLE -> FETCH ->
//   EXEC -> FETCH ...
//   In FETCH it fetches an instruction over a req/ack handshake and latches it.
//   In EXEC it holds the instruction for the datapath. When the datapath
//   reports completion, it resolves the next PC. Sources for the next PC, in
//   priority order: interrupt entry, misalignment trap (optional), taken
//   branch / jal / jalr target, pc+4.
//   It also keeps an exception PC and a retired-instruction counter.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Defined   : a taken target with addr[1:0] != 0 redirects to TRAP_VEC,
//               records the faulting PC in epc and sets the sticky misalign.
//   Undefined : targets are used as computed; misalign_o is tied low.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_req_o      fetch request, high in FETCH
//   imem_addr_o     fetch address (= pc)
//   imem_ack_i      instruction valid on ins_i (only looked at in FETCH)
//   ins_i           instruction from memory
//   ins_q_o         latched instruction, stable through EXEC
//   exec_valid_o    high in EXEC
//   ex_done_i       datapath finished current instruction (only in EXEC)
//   zero_i/lt_i/ltu_i  ALU compare flags for rs1-rs2
//   rs1_val_i       rs1 operand for the jalr target
//   int_req_i       interrupt request (pulse or level), made sticky internally
//   entry_point_i   interrupt target
//   pc_o, pc_plus4_o, link_o   current PC, PC+4, jal/jalr writeback value
//   epc_o           exception PC
//   misalign_o      sticky misaligned-target flag
//   instret_o       retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0028,
    parameter int unsigned     CNT_W    = 32
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0004
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      ins_i,
    output logic [31:0]      ins_q_o,
    output logic             exec_valid_o,
    input  logic             ex_done_i,
    input  logic             zero_i,
    input  logic             lt_i,
    input  logic             ltu_i,
    input  logic [XLEN-1:0]  rs1_val_i,
    input  logic             int_req_i,
    input  logic [XLEN-1:0]  entry_point_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [XLEN-1:0]  link_o,
    output logic [XLEN-1:0]  epc_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Clears bit 0 of the jalr sum.
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              int_pend_q, int_pend_d;
`ifdef MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic              misaligned_s;
`endif

    logic [XLEN-1:0]   seq_pc_s;
    logic [XLEN-1:0]   b_imm_s, j_imm_s, i_imm_s;
    logic              br_cond_s;
    logic              jump_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   flow_pc_s;
    logic              int_take_s;

    assign seq_pc_s = pc_q + XLEN'(32'd4);

    // Immediates are byte offsets, sign-extended from the latched instruction.
    assign b_imm_s = {{(XLEN-13){ins_q[31]}}, ins_q[31], ins_q[7], ins_q[30:25], ins_q[11:8], 1'b0};
    assign j_imm_s = {{(XLEN-21){ins_q[31]}}, ins_q[31], ins_q[19:12], ins_q[20], ins_q[30:21], 1'b0};
    assign i_imm_s = {{(XLEN-12){ins_q[31]}}, ins_q[31:20]};

    // Branch condition selected by funct3; 010/011 are never taken.
    always_comb begin
        br_cond_s = 1'b0;
        case (ins_q[14:12])
            3'b000:  br_cond_s = zero_i;
            3'b001:  br_cond_s = ~zero_i;
            3'b100:  br_cond_s = lt_i;
            3'b101:  br_cond_s = ~lt_i;
            3'b110:  br_cond_s = ltu_i;
            3'b111:  br_cond_s = ~ltu_i;
            default: br_cond_s = 1'b0;
        endcase
    end

    // Control-transfer target and whether it is taken.
    always_comb begin
        jump_s   = 1'b0;
        target_s = seq_pc_s;
        if (ins_q[6:0] == OPC_BRANCH) begin
            jump_s   = br_cond_s;
            target_s = pc_q + b_imm_s;
        end else if (ins_q[6:0] == OPC_JAL) begin
            jump_s   = 1'b1;
            target_s = pc_q + j_imm_s;
        end else if (ins_q[6:0] == OPC_JALR) begin
            jump_s   = 1'b1;
            target_s = (rs1_val_i + i_imm_s) & JALR_MASK;
        end else begin
            jump_s   = 1'b0;
            target_s = seq_pc_s;
        end
    end

    // PC the instruction would hand over to if no interrupt were pending.
`ifdef MISALIGN_TRAP_EN
    assign misaligned_s = jump_s & (target_s[1:0] != 2'b00);
    assign flow_pc_s    = misaligned_s ? TRAP_VEC : (jump_s ? target_s : seq_pc_s);
`else
    assign flow_pc_s    = jump_s ? target_s : seq_pc_s;
`endif

    // A request arriving on the completing clock is honoured right away.
    assign int_take_s = int_pend_q | int_req_i;

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        epc_d      = epc_q;
        instret_d  = instret_q;
        int_pend_d = int_pend_q | int_req_i;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    ins_d   = ins_i;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (ex_done_i) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + CNT_W'(32'd1);
                    if (int_take_s) begin
                        // epc holds the PC the interrupted flow would have continued at.
                        pc_d       = entry_point_i;
                        epc_d      = flow_pc_s;
                        int_pend_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    end else if (misaligned_s) begin
                        pc_d       = TRAP_VEC;
                        epc_d      = pc_q;
                        misalign_d = 1'b1;
`endif
                    end else begin
                        pc_d = flow_pc_s;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ins_q      <= 32'h0000_0000;
            epc_q      <= '0;
            instret_q  <= '0;
            int_pend_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            epc_q      <= epc_d;
            instret_q  <= instret_d;
            int_pend_q <= int_pend_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_o   = (state_q == S_FETCH);
    assign exec_valid_o = (state_q == S_EXEC);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign pc_plus4_o   = seq_pc_s;
    assign link_o       = seq_pc_s;
    assign ins_q_o      = ins_q;
    assign epc_o        = epc_q;
    assign instret_o    = instret_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o   = misalign_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed and randomized bench for pc_sequencer. The reference model decodes
//   immediates arithmetically from the instruction fields and tracks pc, epc,
//   instret, the pending interrupt and the misalign flag as plain variables.
//   Honours MISALIGN_TRAP_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] ins_i;
    logic [31:0] ins_q_o;
    logic        exec_valid_o;
    logic        ex_done_i;
    logic        zero_i, lt_i, ltu_i;
    logic [31:0] rs1_val_i;
    logic        int_req_i;
    logic [31:0] entry_point_i;
    logic [31:0] pc_o, pc_plus4_o, link_o, epc_o;
    logic        misalign_o;
    logic [31:0] instret_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc, m_epc, m_instret;
    bit          m_pend, m_mis;

    localparam logic [31:0] ADDI = 32'h0010_0093;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .ins_i         (ins_i),
        .ins_q_o       (ins_q_o),
        .exec_valid_o  (exec_valid_o),
        .ex_done_i     (ex_done_i),
        .zero_i        (zero_i),
        .lt_i          (lt_i),
        .ltu_i         (ltu_i),
        .rs1_val_i     (rs1_val_i),
        .int_req_i     (int_req_i),
        .entry_point_i (entry_point_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .link_o        (link_o),
        .epc_o         (epc_o),
        .misalign_o    (misalign_o),
        .instret_o     (instret_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction encoders for directed steps.
    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    // Reference: where control goes after instruction w at pc, ignoring interrupts.
    function automatic logic [31:0] model_flow(input logic [31:0] w, input logic [31:0] pc,
                                               input bit z, input bit l, input bit lu,
                                               input logic [31:0] rs1, output bit jumped);
        int  imm;
        bit  take;
        logic [31:0] t;
        jumped = 1'b0;
        case (w[6:0])
            7'b1100011: begin
                imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                      - int'(w[31]) * 4096;
                case (w[14:12])
                    3'd0: take = z;
                    3'd1: take = !z;
                    3'd4: take = l;
                    3'd5: take = !l;
                    3'd6: take = lu;
                    3'd7: take = !lu;
                    default: take = 1'b0;
                endcase
                jumped = take;
                return take ? pc + 32'(imm) : pc + 32'd4;
            end
            7'b1101111: begin
                imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                      - int'(w[31]) * 1048576;
                jumped = 1'b1;
                return pc + 32'(imm);
            end
            7'b1100111: begin
                imm = int'(w[30:20]) - int'(w[31]) * 2048;
                t = rs1 + 32'(imm);
                jumped = 1'b1;
                return t & 32'hFFFF_FFFE;
            end
            default: return pc + 32'd4;
        endcase
    endfunction

    // One full instruction from FETCH entry to the next FETCH.
    // int_mode: 0 none, 1 pulse in first FETCH cycle, 2 on completing cycle,
    //           3 pulse in first EXEC wait cycle.
    task automatic run_instr(input logic [31:0] w, input int ack_wait, input int done_wait,
                             input bit z, input bit l, input bit lu, input logic [31:0] rs1,
                             input int int_mode, input logic [31:0] entry);
        logic [31:0] flow;
        logic [31:0] old_pc;
        bit          jumped, mis;
        check("fetch_req", {63'd0, imem_req_o}, 64'd1);
        check("fetch_addr", {32'd0, imem_addr_o}, {32'd0, m_pc});
        entry_point_i = entry;
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack_i = 1'b0;
            ex_done_i  = 1'b1;
            int_req_i  = (int_mode == 1 && i == 0);
            tick();
            check("wait_req", {63'd0, imem_req_o}, 64'd1);
            check("wait_noexec", {63'd0, exec_valid_o}, 64'd0);
            check("wait_pc", {32'd0, pc_o}, {32'd0, m_pc});
        end
        ins_i      = w;
        imem_ack_i = 1'b1;
        ex_done_i  = 1'b1;
        int_req_i  = (int_mode == 1 && ack_wait == 0);
        tick();
        if (int_mode == 1) m_pend = 1'b1;
        imem_ack_i = 1'b0;
        ex_done_i  = 1'b0;
        int_req_i  = 1'b0;
        ins_i      = $urandom;
        check("exec_valid", {63'd0, exec_valid_o}, 64'd1);
        check("exec_noreq", {63'd0, imem_req_o}, 64'd0);
        check("ins_q", {32'd0, ins_q_o}, {32'd0, w});
        check("link", {32'd0, link_o}, {32'd0, m_pc + 32'd4});
        check("pc_plus4", {32'd0, pc_plus4_o}, {32'd0, m_pc + 32'd4});
        for (int i = 0; i < done_wait; i++) begin
            imem_ack_i = 1'b1;
            int_req_i  = (int_mode == 3 && i == 0);
            tick();
            if (int_mode == 3 && i == 0) m_pend = 1'b1;
            check("exec_hold", {63'd0, exec_valid_o}, 64'd1);
            check("ins_q_hold", {32'd0, ins_q_o}, {32'd0, w});
        end
        imem_ack_i = 1'b0;
        zero_i     = z;
        lt_i       = l;
        ltu_i      = lu;
        rs1_val_i  = rs1;
        ex_done_i  = 1'b1;
        int_req_i  = (int_mode == 2);
        tick();
        ex_done_i  = 1'b0;
        int_req_i  = 1'b0;
        if (int_mode == 2) m_pend = 1'b1;

        old_pc = m_pc;
        flow   = model_flow(w, m_pc, z, l, lu, rs1, jumped);
        mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = jumped && (flow[1:0] != 2'b00);
        if (mis && !m_pend) begin
            m_epc = old_pc;
            m_pc  = 32'h4;
            m_mis = 1'b1;
        end else if (mis) begin
            flow = 32'h4;
        end
`endif
        if (m_pend) begin
            m_epc  = flow;
            m_pc   = entry;
            m_pend = 1'b0;
        end else if (!mis) begin
            m_pc = flow;
        end
        m_instret = m_instret + 32'd1;
        check("pc", {32'd0, pc_o}, {32'd0, m_pc});
        check("instret", {32'd0, instret_o}, {32'd0, m_instret});
        check("epc", {32'd0, epc_o}, {32'd0, m_epc});
        check("misalign", {63'd0, misalign_o}, {63'd0, m_mis});
        check("back_to_fetch", {63'd0, imem_req_o}, 64'd1);
        check("exec_dropped", {63'd0, exec_valid_o}, 64'd0);
    endtask

    initial begin
        int aw, dw, im, opc;
        logic [31:0] w;
        rst_n = 1'b0;
        imem_ack_i = 1'b0; ins_i = 32'd0; ex_done_i = 1'b0;
        zero_i = 1'b0; lt_i = 1'b0; ltu_i = 1'b0; rs1_val_i = 32'd0;
        int_req_i = 1'b0; entry_point_i = 32'd0;
        m_pc = 32'h28; m_epc = 32'd0; m_instret = 32'd0; m_pend = 1'b0; m_mis = 1'b0;

        // Reset state.
        tick(); tick();
        check("rst_pc", {32'd0, pc_o}, 64'h28);
        check("rst_req", {63'd0, imem_req_o}, 64'd0);
        check("rst_exec", {63'd0, exec_valid_o}, 64'd0);
        check("rst_instret", {32'd0, instret_o}, 64'd0);
        check("rst_epc", {32'd0, epc_o}, 64'd0);
        check("rst_ins_q", {32'd0, ins_q_o}, 64'd0);
        check("rst_misalign", {63'd0, misalign_o}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_req", {63'd0, imem_req_o}, 64'd0);
        tick();

        // Directed walk through the documented scenarios.
        run_instr(ADDI, 2, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);             // 0x28 -> 0x2C
        run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);             // 0x2C -> 0x30
        run_instr(enc_b(-8, 3'b000), 0, 1, 1'b1, 1'b0, 1'b0, 32'd0, 0, 32'd0); // beq taken -> 0x28
        run_instr(ADDI, 1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);             // -> 0x2C
        run_instr(enc_j(16), 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);        // jal -> 0x3C
        run_instr(enc_j(-12), 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);       // -> 0x30
        run_instr(enc_b(-8, 3'b000), 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0); // beq not taken -> 0x34
        run_instr(enc_j(-4), 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);        // -> 0x30
        run_instr(enc_b(-8, 3'b111), 0, 0, 1'b0, 1'b0, 1'b1, 32'd0, 0, 32'd0); // bgeu ltu=1 -> 0x34
        check("directed_pc_34", {32'd0, pc_o}, 64'h34);
        run_instr(ADDI, 1, 2, 1'b0, 1'b0, 1'b0, 32'd0, 1, 32'h80);            // interrupt -> 0x80
        check("directed_epc_38", {32'd0, epc_o}, 64'h38);
        run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'h80);            // -> 0x84
        run_instr(enc_jalr(0), 0, 0, 1'b0, 1'b0, 1'b0, 32'h101, 0, 32'd0);    // jalr -> 0x100
        check("directed_pc_100", {32'd0, pc_o}, 64'h100);
        run_instr(enc_jalr(0), 0, 0, 1'b0, 1'b0, 1'b0, 32'h102, 0, 32'd0);    // misaligned target
        run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 2, 32'h200);           // irq on completion

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            w   = $urandom;
            opc = $urandom_range(0, 3);
            case (opc)
                0: w[6:0] = 7'b1100011;
                1: w[6:0] = 7'b1101111;
                2: w[6:0] = 7'b1100111;
                default: w[6:0] = 7'b0010011;
            endcase
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            im = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(w, aw, dw, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, im,
                      $urandom & 32'hFFFF_FFFC);
        end

        // Reset while in EXEC with ex_done high: nothing retires.
        ins_i = ADDI;
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        check("pre_rst_exec", {63'd0, exec_valid_o}, 64'd1);
        ex_done_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_drop", {63'd0, exec_valid_o}, 64'd0);
        check("rst_exec_req", {63'd0, imem_req_o}, 64'd0);
        check("rst_exec_pc", {32'd0, pc_o}, 64'h28);
        tick();
        check("rst_exec_instret", {32'd0, instret_o}, 64'd0);
        ex_done_i = 1'b0;
        rst_n = 1'b1;
        tick();
        check("refetch_req", {63'd0, imem_req_o}, 64'd1);
        check("refetch_addr", {32'd0, imem_addr_o}, 64'h28);

        // Reset while in FETCH drops the request without waiting for a clock.
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_fetch_req", {63'd0, imem_req_o}, 64'd0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
